// File: rtl/transmission_pkg.sv
// Shared constants and types for the 8-channel MUX/DMUX transmission link.
package transmission_pkg;
  localparam int   N_CH_DEF  = 8;
  localparam int   SEL_W_DEF = 3;
  localparam logic IDLE_LVL  = 1'b1;

  typedef logic [SEL_W_DEF-1:0] ch_sel_t;
endpackage

// File: rtl/dmux_1n.sv
// 1:N_CH distributor; every non-addressed output bit sits at the idle level.
module dmux_1n
  import transmission_pkg::*;
#(
  parameter int   N_CH  = N_CH_DEF,
  parameter int   SEL_W = $clog2(N_CH),
  parameter logic IDLE  = IDLE_LVL
) (
  input  logic             line,
  input  logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  data_o
);

  always_comb begin
    data_o      = {N_CH{IDLE}};
    data_o[sel] = line;
  end

endmodule

// File: rtl/mux_n1.sv
// N_CH:1 bit selector; purely combinational.
module mux_n1
  import transmission_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  data_i,
  input  logic [SEL_W-1:0] sel,
  output logic             line
);

  assign line = data_i[sel];

endmodule

// File: rtl/transmission_8.sv
// Time-multiplexed link: iData[{A,B,C}] is carried to the same bit of oData,
// registered on clk; all other oData bits idle high.
module transmission_8
  import transmission_pkg::*;
#(
  parameter int   N_CH  = N_CH_DEF,
  parameter int   SEL_W = SEL_W_DEF,
  parameter logic IDLE  = IDLE_LVL
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] iData,
  input  logic            A,
  input  logic            B,
  input  logic            C,
  output logic [N_CH-1:0] oData
);

  ch_sel_t           sel;
  logic              line;
  logic [N_CH-1:0]   next_data;
  logic [N_CH-1:0]   odata_d;
  logic [N_CH-1:0]   odata_q;

  assign sel = {A, B, C};

  mux_n1 #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_mux (
    .data_i (iData),
    .sel    (sel),
    .line   (line)
  );

  dmux_1n #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W),
    .IDLE  (IDLE)
  ) u_dmux (
    .line   (line),
    .sel    (sel),
    .data_o (next_data)
  );

  always_comb begin
    odata_d = next_data;
  end

  // Output register; reset forces the idle pattern even mid-stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      odata_q <= {N_CH{IDLE}};
    end else begin
      odata_q <= odata_d;
    end
  end

  assign oData = odata_q;

endmodule

// File: tb/tb_transmission_8.sv
// Self-checking bench for transmission_8: directed literal cases plus random
// stimulus compared every cycle against a behavioural model.
module tb_transmission_8;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] iData;
  logic       A, B, C;
  logic [7:0] oData;

  int checks = 0;
  int passes = 0;

  logic [7:0] model_q;
  bit         model_vld = 0;

  always #5 clk = ~clk;

  transmission_8 dut (
    .clk   (clk),
    .rst   (rst),
    .iData (iData),
    .A     (A),
    .B     (B),
    .C     (C),
    .oData (oData)
  );

  // Model: all bits idle high, except the addressed bit which carries its data.
  function automatic logic [7:0] expect_out(logic r, logic [7:0] d, int s);
    logic [7:0] e;
    e = 8'hFF;
    if (!r) e[s] = d[s];
    return e;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    model_q   = expect_out(rst, iData, int'({A, B, C}));
    model_vld = 1;
  end

  always @(negedge clk) begin
    if (model_vld) chk("model", oData, model_q);
  end

  task automatic apply(input logic r, input logic [7:0] d, input int s);
    logic [2:0] s3;
    s3 = s[2:0];
    rst = r;
    iData = d;
    {A, B, C} = s3;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] a5_tab [8];
  logic [7:0] exp_v;

  initial begin
    a5_tab = '{8'hFF, 8'hFD, 8'hFF, 8'hF7, 8'hEF, 8'hFF, 8'hBF, 8'hFF};
    rst = 1'b1;
    iData = 8'h00;
    {A, B, C} = 3'd0;

    apply(1'b1, 8'h00, 0);
    chk("reset_1", oData, 8'hFF);
    apply(1'b1, 8'h00, 0);
    chk("reset_2", oData, 8'hFF);
    rst = 1'b0;
    #1;
    chk("reset_hold", oData, 8'hFF);
    @(posedge clk);
    #1;
    chk("first_after_reset", oData, 8'hFE);

    for (int s = 0; s < 8; s++) begin
      apply(1'b0, 8'h00, s);
      exp_v = 8'h01 << s;
      exp_v = ~exp_v;
      chk("sweep_zero", oData, exp_v);
      if (s == 5) chk("sweep_zero_sel5", oData, 8'b1101_1111);
    end

    for (int s = 0; s < 8; s++) begin
      apply(1'b0, 8'hA5, s);
      chk("sweep_a5", oData, a5_tab[s]);
    end

    for (int s = 0; s < 8; s++) begin
      apply(1'b0, 8'hFF, s);
      chk("sweep_ff", oData, 8'hFF);
    end

    apply(1'b0, 8'h00, 3);
    chk("latency_sel3", oData, 8'hF7);
    {A, B, C} = 3'd6;
    #1;
    chk("latency_hold", oData, 8'hF7);
    @(posedge clk);
    #1;
    chk("latency_sel6", oData, 8'hBF);

    apply(1'b0, 8'h00, 2);
    chk("pre_midreset", oData, 8'hFB);
    apply(1'b1, 8'h00, 2);
    chk("midreset", oData, 8'hFF);
    apply(1'b0, 8'h00, 2);
    chk("post_midreset", oData, 8'hFB);

    for (int i = 0; i < 300; i++) begin
      apply(($urandom_range(0, 15) == 0), 8'($urandom), int'($urandom_range(0, 7)));
    end
    apply(1'b0, 8'h3C, 4);
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
